// File: rtl/axi_lite_led_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_led_ctrl_if
// Brief    : AXI4-Lite bundle between a master and the LED controller slave.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_lite_led_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] s_axi_awaddr;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_led_ctrl
// Brief    : AXI4-Lite LED controller: software pattern or prescaled counter.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_led_ctrl #(
    parameter int                    ADDR_W       = 4,
    parameter int                    PRESCALE_W   = 24,
    parameter logic [PRESCALE_W-1:0] PRESCALE_DEF = 24'd4
) (
    input  wire logic               aclk,
    input  wire logic               areset,
    axi_lite_led_ctrl_if.slave      s_axi,
    input  wire logic               cnt_disp,
    output logic [7:0]              leds
);
    localparam logic [31:0] c_id      = 32'h4C45_4431;
    localparam logic [1:0]  c_reg_led = 2'd0;
    localparam logic [1:0]  c_reg_pre = 2'd1;
    localparam logic [1:0]  c_reg_cnt = 2'd2;
    localparam logic [1:0]  c_reg_id  = 2'd3;

    logic                  r_aw_full;
    logic                  r_w_full;
    logic [1:0]            r_aw_sel;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic                  r_bvalid;
    logic                  r_rvalid;
    logic [31:0]           r_rdata;
    logic [7:0]            r_led;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pc;
    logic [7:0]            r_count;
    logic [7:0]            r_leds;

    logic                  w_awready;
    logic                  w_wready;
    logic                  w_arready;
    logic                  w_commit;
    logic [31:0]           w_mask;
    logic [7:0]            w_led_new;
    logic [31:0]           w_pre_new;
    logic [31:0]           w_rd_mux;
    logic                  w_unused_bits;

    // Readies are gated by reset directly so they read 0 while reset is held.
    assign w_awready = !areset && !r_aw_full && !r_bvalid;
    assign w_wready  = !areset && !r_w_full  && !r_bvalid;
    assign w_arready = !areset && !r_rvalid;
    assign w_commit  = r_aw_full && r_w_full && !r_bvalid;

    always_comb begin
        w_mask = '0;
        for (int b = 0; b < 4; b++) begin
            w_mask[8*b +: 8] = {8{r_wstrb[b]}};
        end
    end

    assign w_led_new = (r_led & ~w_mask[7:0]) | (r_wdata[7:0] & w_mask[7:0]);
    assign w_pre_new = (32'(r_prescale) & ~w_mask) | (r_wdata & w_mask);

    always_comb begin
        w_rd_mux = '0;
        case (s_axi.s_axi_araddr[3:2])
            c_reg_led: w_rd_mux = {24'd0, r_led};
            c_reg_pre: w_rd_mux = 32'(r_prescale);
            c_reg_cnt: w_rd_mux = {24'd0, r_count};
            c_reg_id:  w_rd_mux = c_id;
            default:   w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_aw_sel  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
        end else begin
            if (s_axi.s_axi_awvalid && w_awready) begin
                r_aw_full <= 1'b1;
                r_aw_sel  <= s_axi.s_axi_awaddr[3:2];
            end
            if (s_axi.s_axi_wvalid && w_wready) begin
                r_w_full <= 1'b1;
                r_wdata  <= s_axi.s_axi_wdata;
                r_wstrb  <= s_axi.s_axi_wstrb;
            end
            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
            end else if (r_bvalid && s_axi.s_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Counter and register file; a PRESCALE write restarts the prescale phase.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_led      <= '0;
            r_prescale <= PRESCALE_DEF;
            r_pc       <= '0;
            r_count    <= '0;
        end else begin
            if (r_pc == r_prescale) begin
                r_pc    <= '0;
                r_count <= r_count + 8'd1;
            end else begin
                r_pc <= r_pc + 1'b1;
            end
            if (w_commit && r_aw_sel == c_reg_led) begin
                r_led <= w_led_new;
            end
            if (w_commit && r_aw_sel == c_reg_pre) begin
                r_prescale <= w_pre_new[PRESCALE_W-1:0];
                r_pc       <= '0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_leds   <= '0;
        end else begin
            if (s_axi.s_axi_arvalid && w_arready) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
            end else if (r_rvalid && s_axi.s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
            r_leds <= cnt_disp ? r_count : r_led;
        end
    end

    assign s_axi.s_axi_awready = w_awready;
    assign s_axi.s_axi_wready  = w_wready;
    assign s_axi.s_axi_bvalid  = r_bvalid;
    assign s_axi.s_axi_bresp   = 2'b00;
    assign s_axi.s_axi_arready = w_arready;
    assign s_axi.s_axi_rvalid  = r_rvalid;
    assign s_axi.s_axi_rdata   = r_rdata;
    assign s_axi.s_axi_rresp   = 2'b00;
    assign leds                = r_leds;

    // Address low bits and prescale bits above PRESCALE_W carry no state.
    assign w_unused_bits = ^{s_axi.s_axi_awaddr, s_axi.s_axi_araddr, w_pre_new};
endmodule
`default_nettype wire
